// File: rtl/mem_access_stage.sv
// Memory stage: EX/MEM register, single-outstanding data-memory handshake, byte-lane alignment, MEM/WB register.
// Optional build macro MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into faults instead of bus requests.
module mem_access_stage #(
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic [31:0] ex_alu_result,
    input  logic [31:0] ex_rs2_data,
    input  logic        ex_mem_read,
    input  logic        ex_mem_write,
    input  logic [1:0]  ex_mem_size,
    input  logic        ex_mem_unsigned,
    input  logic [4:0]  ex_rd,
    input  logic        ex_reg_write,
    output logic        mem_stall,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_rd,
    output logic        wb_reg_write,
    output logic        fault,
    output logic [31:0] fault_addr,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    state_t      r_state, w_next_state;
    logic [31:0] r_wait_cnt;

    logic        r_m_valid, r_m_read, r_m_write, r_m_unsigned, r_m_reg_write;
    logic [31:0] r_m_addr, r_m_wdata;
    logic [1:0]  r_m_size;
    logic [4:0]  r_m_rd;

    logic        r_wb_valid, r_wb_reg_write;
    logic [31:0] r_wb_data;
    logic [4:0]  r_wb_rd;

    logic        w_mem_op, w_misaligned, w_req, w_ready, w_stall, w_retire;
    logic [3:0]  w_be;
    logic [31:0] w_wdata, w_load_data;
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_mem_op = r_m_valid & (r_m_read | r_m_write);

`ifdef MEM_MISALIGN_TRAP_EN
    assign w_misaligned = ((r_m_size == 2'b01) && r_m_addr[0]) ||
                          (r_m_size[1] && (r_m_addr[1:0] != 2'b00));
`else
    assign w_misaligned = 1'b0;
`endif

    // A ready that arrives while no request is up is never seen by the stage.
    assign w_req    = w_mem_op & ~w_misaligned & (r_state != ST_FAULT);
    assign w_ready  = w_req & dmem_ready;
    assign w_stall  = w_mem_op & ~w_ready & (r_state != ST_FAULT);
    assign w_retire = r_m_valid & (r_state != ST_FAULT) &
                      (~(r_m_read | r_m_write) | w_ready);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid     <= 1'b0;
            r_m_read      <= 1'b0;
            r_m_write     <= 1'b0;
            r_m_unsigned  <= 1'b0;
            r_m_reg_write <= 1'b0;
            r_m_addr      <= 32'h0;
            r_m_wdata     <= 32'h0;
            r_m_size      <= 2'b00;
            r_m_rd        <= 5'h0;
        end else if (!w_stall) begin
            r_m_valid     <= ex_valid;
            r_m_read      <= ex_mem_read;
            r_m_write     <= ex_mem_write;
            r_m_unsigned  <= ex_mem_unsigned;
            r_m_reg_write <= ex_reg_write;
            r_m_addr      <= ex_alu_result;
            r_m_wdata     <= ex_rs2_data;
            r_m_size      <= ex_mem_size;
            r_m_rd        <= ex_rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 32'h0;
        end else begin
            r_state <= w_next_state;
            if (r_state == ST_IDLE && w_next_state == ST_WAIT)
                r_wait_cnt <= 32'd1;
            else if (r_state == ST_WAIT && w_next_state == ST_WAIT)
                r_wait_cnt <= r_wait_cnt + 32'd1;
            else
                r_wait_cnt <= 32'h0;
        end
    end

    // The counter counts request cycles already spent; the edge that would reach the limit faults.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_mem_op && !w_ready) begin
                    if (w_misaligned || BUS_TIMEOUT == 1)
                        w_next_state = ST_FAULT;
                    else
                        w_next_state = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_ready)
                    w_next_state = ST_IDLE;
                else if (BUS_TIMEOUT != 0 && (r_wait_cnt + 32'd1) == BUS_TIMEOUT)
                    w_next_state = ST_FAULT;
            end
            ST_FAULT: w_next_state = ST_IDLE;
            default:  w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_be    = 4'b1111;
        w_wdata = r_m_wdata;
        case (r_m_size)
            2'b00: begin
                w_be    = 4'b0001 << r_m_addr[1:0];
                w_wdata = {4{r_m_wdata[7:0]}};
            end
            2'b01: begin
                w_be    = r_m_addr[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{r_m_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        w_byte      = dmem_rdata[{r_m_addr[1:0], 3'b000} +: 8];
        w_half      = r_m_addr[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        w_load_data = dmem_rdata;
        case (r_m_size)
            2'b00:   w_load_data = {{24{~r_m_unsigned & w_byte[7]}}, w_byte};
            2'b01:   w_load_data = {{16{~r_m_unsigned & w_half[15]}}, w_half};
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
            r_wb_data      <= 32'h0;
            r_wb_rd        <= 5'h0;
        end else if (w_retire) begin
            r_wb_valid     <= 1'b1;
            r_wb_reg_write <= r_m_reg_write;
            r_wb_data      <= r_m_read ? w_load_data : r_m_addr;
            r_wb_rd        <= r_m_rd;
        end else begin
            r_wb_valid     <= 1'b0;
            r_wb_reg_write <= 1'b0;
        end
    end

    assign mem_stall    = w_stall;
    assign dmem_req     = w_req;
    assign dmem_we      = w_req & r_m_write;
    assign dmem_addr    = {r_m_addr[31:2], 2'b00};
    assign dmem_wdata   = w_wdata;
    assign dmem_be      = w_req ? w_be : 4'b0000;
    assign wb_valid     = r_wb_valid;
    assign wb_data      = r_wb_data;
    assign wb_rd        = r_wb_rd;
    assign wb_reg_write = r_wb_reg_write;
    assign fault        = (r_state == ST_FAULT);
    assign fault_addr   = (r_state == ST_FAULT) ? r_m_addr : 32'h0;
    assign dbg_state    = r_state;

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory stage of the 5-stage pipeline, directly downstream of the execute-stage ALU. Holds the EX/MEM pipeline register, uses the ALU result as the load/store address, drives a single-outstanding data-memory request/ready handshake, aligns store data and load data by byte lane, and produces the MEM/WB register contents. Stalls upstream stages while a memory access is outstanding and reports bus timeouts and (optionally) misaligned accesses as faults.

## Interface
- BUS_TIMEOUT, 255: wait cycles before an unanswered request faults; 0 disables timeout.
- clk  in  1  clock, all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  EX stage presents a valid instruction.
- ex_alu_result  in  32  ALU result: address for loads/stores, writeback value otherwise.
- ex_rs2_data  in  32  store data.
- ex_mem_read / ex_mem_write  in  1 each  load / store (never both).
- ex_mem_size  in  2  00 byte, 01 half, 10 word, 11 treated as word.
- ex_mem_unsigned  in  1  zero-extend loads when 1.
- ex_rd  in  5  destination register; ex_reg_write  in  1  writeback enable.
- mem_stall  out  1  upstream must hold its outputs; ex_* ignored while high.
- dmem_req  out  1; dmem_we  out  1; dmem_addr  out  32 (bits [1:0] always 0); dmem_wdata  out  32; dmem_be  out  4.
- dmem_ready  in  1; dmem_rdata  in  32  valid when dmem_ready.
- wb_valid  out  1; wb_data  out  32; wb_rd  out  5; wb_reg_write  out  1.
- fault  out  1  one-cycle pulse; fault_addr  out  32  offending byte address.

## Operation
- EX/MEM register (m_*) loads ex_* on every edge where mem_stall=0; ex_valid=0 loads a bubble.
- FSM: IDLE, WAIT, FAULT.
  - IDLE: m_valid with mem op asserts dmem_req combinationally. dmem_ready same cycle -> completes, stay IDLE. Otherwise -> WAIT, wait counter=1.
  - WAIT: dmem_req held, all dmem_* stable. dmem_ready -> complete, IDLE. Counter reaching BUS_TIMEOUT without ready -> FAULT (dmem_req drops that edge).
  - FAULT: one cycle; fault=1, fault_addr=m address, dmem_req=0, mem_stall=0, instruction retires as bubble (wb_valid=0 next); -> IDLE.
- mem_stall = m_valid & mem op & ~dmem_ready & state!=FAULT.
- MEM/WB register: on completion or non-mem valid instruction, wb_valid=m_valid, wb_rd, wb_reg_write copied; wb_data = aligned load data or m ALU result. During stall or FAULT, wb_valid=0 and wb_reg_write=0 (bubble).
- Stores: byte -> wdata={4{b}}, be=1<<addr[1:0]; half -> wdata={2{h}}, be=addr[1]?1100:0011; word -> be=1111. Loads: be as above, dmem_we=0.
- Load align: byte lane addr[1:0], half lane addr[1]; sign-extend unless ex_mem_unsigned. Word loads pass through.
- Store completion writes wb_valid=1 with wb_reg_write as given (normally 0).

## Timing
- Reset: all outputs 0, state IDLE, m_valid=0, counter 0. Reset mid-access drops dmem_req immediately (asynchronous); no completion reported.
- Non-mem instruction and zero-wait access: ex inputs at edge N -> wb_* valid after edge N+1.
- Each dmem_ready=0 cycle adds one cycle latency and one bubble on wb.
- New ex instruction accepted on the same edge a request completes (back-to-back accesses, no idle cycle).
- Timeout: fault pulses BUS_TIMEOUT cycles after the request first asserted; with BUS_TIMEOUT=0 the stage waits forever.
- dmem_ready outside dmem_req is ignored.

## Configuration
- MEM_MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]!=0 never asserts dmem_req; enters FAULT directly the cycle after capture (fault=1, fault_addr=address, bubble to wb).
- Undefined: misaligned accesses issue with low address bits ignored per lane rules (half uses addr[1], word uses lane 0); no fault.

## Test plan
- ADD result 0x0000_1234, rd=5, no mem op -> two edges later wb_valid=1, wb_data=0x1234, wb_rd=5, dmem_req never high.
- LB addr 0x103, dmem_rdata=0x80FF_0000, ready same cycle -> dmem_addr=0x100, be=1000, wb_data=0xFFFF_FF80; with unsigned, 0x0000_0080.
- SH addr 0x202, rs2=0xABCD_1234, ready after 3 cycles -> wdata=0x1234_1234, be=1100, we=1, mem_stall high 3 cycles, 3 wb bubbles.
- BUS_TIMEOUT=4, LW with ready held 0 -> fault pulses one cycle with fault_addr, dmem_req drops, wb_valid=0, next instruction accepted.
- LW addr 0x101: with MEM_MISALIGN_TRAP_EN -> no dmem_req, fault=1, fault_addr=0x101; without -> dmem_addr=0x100, be=1111, normal completion.
- rst_n low during WAIT -> dmem_req, mem_stall, wb_valid all 0 immediately; after release, clean LW completes normally.
